// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Reads back a multiplexed, active-low 7-segment display bus. It recovers
//   the 4-bit code shown on each digit. This is the inverse of the BCD-to-
//   7-segment encoder.
//
//   A segment/select pair must be seen unchanged for STABLE_CYCLES registered
//   samples before it is captured. Capture happens once per dwell. Only
//   one-hot (single low) selects are considered.
//
// Parameters
//   NUM_DIGITS     number of scanned digits (1-8)
//   STABLE_CYCLES  consecutive identical samples needed before capture (2-255)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg         segment lines, seg[6]=a .. seg[0]=g, active-low (0 = lit)
//   dig_sel     digit enables, active-low, one-hot when meaningful
//   digits      decoded codes, digit k at [4k+3:4k]
//   valid       digit k holds a legal decoded value
//   err         last qualified pattern on digit k was illegal
//   frame_done  one-cycle pulse when every digit has been captured since
//               the previous pulse
//
// Build option
//   SEG7DEC_HEX_EN  when defined, also decode A b C d E F as 0xA-0xF;
//                   otherwise those six patterns are treated as illegal.

module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    PAT_LEGAL,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_class_t;

  // Input registers and the previous registered pair, used for the
  // stability comparison.
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [6:0]            seg_prev;
  logic [NUM_DIGITS-1:0] sel_prev;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] seen;

  logic [NUM_DIGITS-1:0]   sel_low;
  logic [3:0]              low_cnt;
  logic [IW-1:0]           sel_idx;
  logic                    qualified;
  logic                    pair_same;
  logic [CW-1:0]           cnt_next;
  logic                    capture;
  logic [6:0]              lit;
  logic [3:0]              dec_code;
  pat_class_t              dec_class;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic [NUM_DIGITS-1:0]   seen_or;
  logic                    frame_hit;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic [4*NUM_DIGITS-1:0] digits_next;
  logic [NUM_DIGITS-1:0]   valid_next;
  logic [NUM_DIGITS-1:0]   err_next;

  // Select qualification: exactly one active-low enable asserted.
  always_comb begin
    sel_low = ~sel_q;
    low_cnt = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_low[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = i[IW-1:0];
      end
    end
    qualified = (low_cnt == 4'd1);
  end

  // Stability counter. A change in the registered pair restarts it at 1,
  // and it saturates at STABLE_CYCLES. The capture fires only on the edge
  // where the counter first reaches the limit, so a long dwell captures
  // once.
  always_comb begin
    pair_same = (seg_q == seg_prev) && (sel_q == sel_prev);
    if (!qualified) begin
      cnt_next = '0;
    end else if (!pair_same) begin
      cnt_next = CW'(1);
    end else if (cnt == CNT_FULL) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CW'(1);
    end
    capture = (cnt_next == CNT_FULL) && (cnt != CNT_FULL);
  end

  // Pattern decode on the lit-segment set (a in bit 6 .. g in bit 0).
  always_comb begin
    lit       = ~seg_q;
    dec_code  = 4'h0;
    dec_class = PAT_ILLEGAL;
    case (lit)
      7'h7E: begin dec_code = 4'h0; dec_class = PAT_LEGAL; end
      7'h30: begin dec_code = 4'h1; dec_class = PAT_LEGAL; end
      7'h6D: begin dec_code = 4'h2; dec_class = PAT_LEGAL; end
      7'h79: begin dec_code = 4'h3; dec_class = PAT_LEGAL; end
      7'h33: begin dec_code = 4'h4; dec_class = PAT_LEGAL; end
      7'h5B: begin dec_code = 4'h5; dec_class = PAT_LEGAL; end
      7'h5F: begin dec_code = 4'h6; dec_class = PAT_LEGAL; end
      7'h70: begin dec_code = 4'h7; dec_class = PAT_LEGAL; end
      7'h7F: begin dec_code = 4'h8; dec_class = PAT_LEGAL; end
      7'h7B: begin dec_code = 4'h9; dec_class = PAT_LEGAL; end
`ifdef SEG7DEC_HEX_EN
      7'h77: begin dec_code = 4'hA; dec_class = PAT_LEGAL; end
      7'h1F: begin dec_code = 4'hB; dec_class = PAT_LEGAL; end
      7'h4E: begin dec_code = 4'hC; dec_class = PAT_LEGAL; end
      7'h3D: begin dec_code = 4'hD; dec_class = PAT_LEGAL; end
      7'h4F: begin dec_code = 4'hE; dec_class = PAT_LEGAL; end
      7'h47: begin dec_code = 4'hF; dec_class = PAT_LEGAL; end
`endif
      7'h00:   dec_class = PAT_BLANK;
      default: dec_class = PAT_ILLEGAL;
    endcase
  end

  // Per-digit output update on capture.
  always_comb begin
    digits_next = digits;
    valid_next  = valid;
    err_next    = err;
    if (capture) begin
      case (dec_class)
        PAT_LEGAL: begin
          digits_next[{sel_idx, 2'b00} +: 4] = dec_code;
          valid_next[sel_idx]                = 1'b1;
          err_next[sel_idx]                  = 1'b0;
        end
        PAT_BLANK: begin
          valid_next[sel_idx] = 1'b0;
          err_next[sel_idx]   = 1'b0;
        end
        default: begin
          valid_next[sel_idx] = 1'b0;
          err_next[sel_idx]   = 1'b1;
        end
      endcase
    end
  end

  // Frame tracking. The capture that completes the mask lands on the same
  // edge as the clear, so its own bit is re-set. That bit then counts
  // toward the next frame.
  always_comb begin
    cap_mask  = capture ? sel_low : '0;
    seen_or   = seen | cap_mask;
    frame_hit = &seen_or;
    seen_next = frame_hit ? cap_mask : seen_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '1;
      sel_q      <= '1;
      seg_prev   <= '1;
      sel_prev   <= '1;
      cnt        <= '0;
      seen       <= '0;
      digits     <= '0;
      valid      <= '0;
      err        <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_q      <= seg;
      sel_q      <= dig_sel;
      seg_prev   <= seg_q;
      sel_prev   <= sel_q;
      cnt        <= cnt_next;
      seen       <= seen_next;
      digits     <= digits_next;
      valid      <= valid_next;
      err        <= err_next;
      frame_done <= frame_hit;
    end
  end

endmodule
